// File: rtl/verisparse_pkg.sv
// Shared verisparse definitions: fixed-point data type, data bus width and
// the residual updater state encoding.
package verisparse_pkg;

  localparam int FP_DATA_BUS_WIDTH = 32;

  typedef logic signed [FP_DATA_BUS_WIDTH-1:0] fp_32_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } vs_residual_updater_state_t;

endpackage

// File: rtl/vs_square_accumulator.sv
// Running sum of squares of signed 32-bit values, wrapping modulo 2^64.
// Ports:
//   clock, reset_n  : clock / async active-low reset
//   clear           : zero the sum (takes priority over accumulate)
//   accumulate      : add value^2 to the sum this cycle
//   value           : signed 32-bit sample
//   sum_sq          : registered 64-bit sum
module vs_square_accumulator
  import verisparse_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         accumulate,
  input  logic [FP_DATA_BUS_WIDTH-1:0] value,
  output logic [63:0]                  sum_sq
);

  logic signed [63:0] v_ext;
  logic signed [63:0] sq;

  assign v_ext = 64'($signed(value));
  assign sq    = v_ext * v_ext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        sum_sq <= '0;
    else if (clear)      sum_sq <= '0;
    else if (accumulate) sum_sq <= sum_sq + 64'(sq);
  end

endmodule

// File: rtl/vs_residual_updater.sv
// Matching-pursuit residual update: r <- r - alpha * phi[:,k].
// Reads column k of the sensing matrix and the residual through 1-cycle
// synchronous RAM ports, writes each corrected row back to the residual RAM.
// Optional build macro: VS_RESIDUAL_NORM_EN adds residual_norm_sq (sum of y^2).
// Ports:
//   clock, reset_n            : clock / async active-low reset
//   start, column, alpha      : request (sampled in IDLE only)
//   phi_read_addr/data        : sensing-matrix RAM read port
//   res_read_addr/data        : residual RAM read port
//   res_write_enable/addr/data: residual RAM write port
//   busy, done, error         : status; error pulses with done on bad column
//   residual_norm_sq          : (VS_RESIDUAL_NORM_EN) squared norm of result
module vs_residual_updater
  import verisparse_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLUMNS        = 8,
  parameter int RES_ADDR_WIDTH = 8,
  parameter int PHI_ADDR_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [7:0]                   column,
  input  logic [FP_DATA_BUS_WIDTH-1:0] alpha,
  output logic [PHI_ADDR_WIDTH-1:0]    phi_read_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0] phi_read_data,
  output logic [RES_ADDR_WIDTH-1:0]    res_read_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0] res_read_data,
  output logic                         res_write_enable,
  output logic [RES_ADDR_WIDTH-1:0]    res_write_addr,
  output logic [FP_DATA_BUS_WIDTH-1:0] res_write_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error
`ifdef VS_RESIDUAL_NORM_EN
  ,
  output logic [63:0]                  residual_norm_sq
`endif
);

  localparam logic [RES_ADDR_WIDTH-1:0] LAST_ROW = RES_ADDR_WIDTH'(ROWS - 1);

  vs_residual_updater_state_t state_q, state_d;

  logic [7:0]                col_q;
  fp_32_t                    alpha_q;
  logic [RES_ADDR_WIDTH-1:0] row_i;
  logic                      err_q;

  // vld_pipe[0]: read data for rd_row is on the RAM outputs this cycle
  // vld_pipe[1]: write port is driving a row this cycle
  logic [1:0]                vld_pipe;
  logic [RES_ADDR_WIDTH-1:0] rd_row;

  logic                      issue;
  logic                      accept;
  logic                      bad_col;

  logic signed [63:0]        a_ext, p_ext, prod;
  logic [FP_DATA_BUS_WIDTH-1:0] y;

  // The done cycle is still part of the operation (busy high), so a start
  // landing there is not taken.
  assign accept  = start && (state_q == IDLE) && !done;
  assign bad_col = int'(column) >= COLUMNS;
  assign issue   = (state_q == ISSUE);
  assign busy    = (state_q != IDLE) || done;

  assign phi_read_addr = issue ? (PHI_ADDR_WIDTH'(col_q) * PHI_ADDR_WIDTH'(ROWS)
                                  + PHI_ADDR_WIDTH'(row_i)) : '0;
  assign res_read_addr = issue ? row_i : '0;

  // Full signed 64-bit product; only the low word feeds the wrapping subtract.
  assign a_ext = 64'(alpha_q);
  assign p_ext = 64'($signed(phi_read_data));
  assign prod  = a_ext * p_ext;
  assign y     = res_read_data - prod[31:0];

  assign res_write_enable = vld_pipe[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = bad_col ? FINISH : ISSUE;
      ISSUE:  if (row_i == LAST_ROW) state_d = DRAIN;
      // Last row's data is on the read ports; its write is registered on this
      // edge and is driven during FINISH, with done following one cycle later.
      DRAIN:  if (vld_pipe[0] && rd_row == LAST_ROW) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      col_q          <= '0;
      alpha_q        <= '0;
      row_i          <= '0;
      err_q          <= 1'b0;
      vld_pipe       <= '0;
      rd_row         <= '0;
      res_write_addr <= '0;
      res_write_data <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        col_q   <= column;
        alpha_q <= alpha;
        row_i   <= '0;
        err_q   <= bad_col;
      end else if (issue) begin
        row_i <= row_i + 1'b1;
      end
      vld_pipe[0]    <= issue;
      rd_row         <= row_i;
      vld_pipe[1]    <= vld_pipe[0];
      res_write_addr <= vld_pipe[0] ? rd_row : '0;
      res_write_data <= vld_pipe[0] ? y : '0;
      done           <= (state_q == FINISH);
      error          <= (state_q == FINISH) && err_q;
    end
  end

`ifdef VS_RESIDUAL_NORM_EN
  vs_square_accumulator u_norm (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (accept),
    .accumulate (vld_pipe[0]),
    .value      (y),
    .sum_sq     (residual_norm_sq)
  );
`endif

endmodule
